// File: rtl/envia_medida_pkg.sv
// Shared definitions for the envia_medida_serial block: FSM codes, ASCII
// constants, frame geometry and the digit-to-ASCII helper.
// Optional build macro: ENVIA_MEDIDA_CRLF_EN (appends CR LF to each frame).
package envia_medida_pkg;

    // FSM state codes, also shown on the debug display
    localparam logic [3:0] EST_IDLE      = 4'h0;
    localparam logic [3:0] EST_REGISTRA  = 4'h1;
    localparam logic [3:0] EST_TRANSMITE = 4'h2;
    localparam logic [3:0] EST_ESPERA    = 4'h3;
    localparam logic [3:0] EST_PROXIMO   = 4'h4;
    localparam logic [3:0] EST_FIM       = 4'hF;

    typedef enum logic [3:0] {
        IDLE      = EST_IDLE,
        REGISTRA  = EST_REGISTRA,
        TRANSMITE = EST_TRANSMITE,
        ESPERA    = EST_ESPERA,
        PROXIMO   = EST_PROXIMO,
        FIM       = EST_FIM
    } estado_t;

    // ASCII characters used in the frame
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_HASH  = 8'h23;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    // start + 8 data + 2 stop
    localparam int BITS_POR_QUADRO = 11;

`ifdef ENVIA_MEDIDA_CRLF_EN
    localparam logic [2:0] ULTIMO_INDICE = 3'd5;
`else
    localparam logic [2:0] ULTIMO_INDICE = 3'd3;
`endif

    // BCD nibble to ASCII digit; non-decimal nibbles become '?'
    function automatic logic [7:0] digito_ascii(input logic [3:0] nib);
        if (nib <= 4'd9) begin
            return ASCII_ZERO + {4'h0, nib};
        end else begin
            return ASCII_QMARK;
        end
    endfunction

endpackage

// File: rtl/tx_serial_8n2.sv
// Bit-level asynchronous transmitter: 8 data bits, no parity, 2 stop bits,
// LSB first. partida loads a byte; pronto_tx is high on the final cycle of
// the second stop bit. The line is registered and idles high.
module tx_serial_8n2
    import envia_medida_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       partida,
    input  logic [7:0] dados,
    output logic       saida_serial,
    output logic       pronto_tx
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX    = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    BIT_ULTIMO = 4'(BITS_POR_QUADRO - 1);

    logic          ativo_r;
    logic [CW-1:0] cont_clk_r;
    logic [3:0]    cont_bit_r;
    logic [9:0]    desloc_r;
    logic          linha_r;
    logic          fim_periodo_s;

    assign fim_periodo_s = (cont_clk_r == CNT_MAX);
    assign pronto_tx     = ativo_r && fim_periodo_s && (cont_bit_r == BIT_ULTIMO);
    assign saida_serial  = linha_r;

    // Bit timing, bit counting and shifting of the outgoing frame
    always_ff @(posedge clock) begin
        if (!reset) begin
            ativo_r    <= 1'b0;
            cont_clk_r <= '0;
            cont_bit_r <= 4'd0;
            desloc_r   <= '1;
            linha_r    <= 1'b1;
        end else if (partida) begin
            // start bit goes out immediately; remaining bits wait in the shifter
            ativo_r    <= 1'b1;
            cont_clk_r <= '0;
            cont_bit_r <= 4'd0;
            desloc_r   <= {2'b11, dados};
            linha_r    <= 1'b0;
        end else if (ativo_r) begin
            if (fim_periodo_s) begin
                cont_clk_r <= '0;
                if (cont_bit_r == BIT_ULTIMO) begin
                    ativo_r <= 1'b0;
                    linha_r <= 1'b1;
                end else begin
                    cont_bit_r <= cont_bit_r + 4'd1;
                    linha_r    <= desloc_r[0];
                    desloc_r   <= {1'b1, desloc_r[9:1]};
                end
            end else begin
                cont_clk_r <= cont_clk_r + CW'(1);
            end
        end else begin
            linha_r <= 1'b1;
        end
    end

endmodule

// File: rtl/envia_medida_serial.sv
// Sends a 3-digit BCD distance as the ASCII frame "ddd#" over an 8N2 serial
// line. Optional build macro ENVIA_MEDIDA_CRLF_EN appends CR LF to the frame.
module envia_medida_serial
    import envia_medida_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enviar,
    input  logic [11:0] medida,
    output logic        saida_serial,
    output logic        ocupado,
    output logic        pronto,
    output logic [3:0]  db_estado
);

    estado_t     estado_r, proximo_s;
    logic [11:0] medida_r;
    logic [2:0]  indice_r;
    logic [7:0]  caractere_s;
    logic        partida_s;
    logic        pronto_tx_s;
    logic        ocupado_r, pronto_r;
    logic [3:0]  db_estado_r;

    assign partida_s = (estado_r == TRANSMITE);
    assign ocupado   = ocupado_r;
    assign pronto    = pronto_r;
    assign db_estado = db_estado_r;

    tx_serial_8n2 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clock       (clock),
        .reset       (reset),
        .partida     (partida_s),
        .dados       (caractere_s),
        .saida_serial(saida_serial),
        .pronto_tx   (pronto_tx_s)
    );

    // State register and status outputs, registered from the next state
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_r    <= IDLE;
            ocupado_r   <= 1'b0;
            pronto_r    <= 1'b0;
            db_estado_r <= EST_IDLE;
        end else begin
            estado_r    <= proximo_s;
            ocupado_r   <= (proximo_s != IDLE);
            pronto_r    <= (proximo_s == FIM);
            db_estado_r <= proximo_s;
        end
    end

    // Next-state logic of the control FSM
    always_comb begin
        proximo_s = estado_r;
        case (estado_r)
            IDLE: begin
                if (enviar) proximo_s = REGISTRA;
                else        proximo_s = IDLE;
            end
            REGISTRA:  proximo_s = TRANSMITE;
            TRANSMITE: proximo_s = ESPERA;
            ESPERA: begin
                if (pronto_tx_s) proximo_s = PROXIMO;
                else             proximo_s = ESPERA;
            end
            PROXIMO: begin
                if (indice_r == ULTIMO_INDICE) proximo_s = FIM;
                else                           proximo_s = TRANSMITE;
            end
            FIM:     proximo_s = IDLE;
            default: proximo_s = IDLE;
        endcase
    end

    // Measurement capture and character index sequencing
    always_ff @(posedge clock) begin
        if (!reset) begin
            medida_r <= 12'h000;
            indice_r <= 3'd0;
        end else if ((estado_r == IDLE) && enviar) begin
            // frozen for the whole frame so later input changes cannot tear it
            medida_r <= medida;
        end else if (estado_r == REGISTRA) begin
            indice_r <= 3'd0;
        end else if ((estado_r == PROXIMO) && (indice_r != ULTIMO_INDICE)) begin
            indice_r <= indice_r + 3'd1;
        end else begin
            indice_r <= indice_r;
        end
    end

    // Character selected by the current index
    always_comb begin
        caractere_s = ASCII_HASH;
        case (indice_r)
            3'd0:    caractere_s = digito_ascii(medida_r[11:8]);
            3'd1:    caractere_s = digito_ascii(medida_r[7:4]);
            3'd2:    caractere_s = digito_ascii(medida_r[3:0]);
            3'd3:    caractere_s = ASCII_HASH;
`ifdef ENVIA_MEDIDA_CRLF_EN
            3'd4:    caractere_s = ASCII_CR;
            3'd5:    caractere_s = ASCII_LF;
`endif
            default: caractere_s = ASCII_HASH;
        endcase
    end

endmodule

// File: tb/tb_envia_medida_serial.sv
// Self-checking bench for envia_medida_serial with CLKS_PER_BIT=4.
// A line monitor decodes received bytes into a queue; expected bytes are
// queued when each frame is requested and compared after pronto.
module tb_envia_medida_serial;

    localparam int CPB = 4;
`ifdef ENVIA_MEDIDA_CRLF_EN
    localparam int NCH = 6;
`else
    localparam int NCH = 4;
`endif
    localparam int LAT = 3 + NCH * 11 * CPB + (NCH - 1) * 2 + 1;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enviar = 1'b0;
    logic [11:0] medida = 12'h000;
    logic        saida_serial;
    logic        ocupado;
    logic        pronto;
    logic [3:0]  db_estado;

    int checks = 0;
    int passes = 0;
    int pronto_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];

    envia_medida_serial #(.CLKS_PER_BIT(CPB)) dut (
        .clock       (clock),
        .reset       (reset),
        .enviar      (enviar),
        .medida      (medida),
        .saida_serial(saida_serial),
        .ocupado     (ocupado),
        .pronto      (pronto),
        .db_estado   (db_estado)
    );

    always #5 clock = ~clock;

    // count pronto pulses
    always @(negedge clock) if (pronto === 1'b1) pronto_cnt++;

    // serial line decoder, sampling mid-bit on falling edges
    initial begin
        logic [7:0] b;
        logic ok;
        forever begin
            @(negedge clock);
            if (saida_serial === 1'b0) begin
                repeat (2) @(negedge clock);
                if (saida_serial === 1'b0) begin
                    for (int k = 0; k < 8; k++) begin
                        repeat (CPB) @(negedge clock);
                        b[k] = saida_serial;
                    end
                    repeat (CPB) @(negedge clock);
                    ok = (saida_serial === 1'b1);
                    repeat (CPB) @(negedge clock);
                    ok = ok && (saida_serial === 1'b1);
                    // a bad stop bit is recorded as an impossible byte marker
                    rx_q.push_back(ok ? b : 8'hxx);
                end
            end
        end
    end

    function automatic logic [7:0] exp_char(input logic [11:0] m, input int i);
        logic [3:0] nib;
        case (i)
            0: nib = m[11:8];
            1: nib = m[7:4];
            2: nib = m[3:0];
            3: return 8'h23;
            4: return 8'h0D;
            default: return 8'h0A;
        endcase
        if (nib > 4'd9) return 8'h3F;
        return 8'h30 + {4'h0, nib};
    endfunction

    task automatic test_reset();
        @(negedge clock);
        checks++; if (saida_serial !== 1'b1) $display("FAIL reset_line got=%b exp=1", saida_serial); else passes++;
        checks++; if (ocupado !== 1'b0) $display("FAIL reset_ocupado got=%b exp=0", ocupado); else passes++;
        checks++; if (pronto !== 1'b0) $display("FAIL reset_pronto got=%b exp=0", pronto); else passes++;
        checks++; if (db_estado !== 4'h0) $display("FAIL reset_db got=%h exp=0", db_estado); else passes++;
    endtask

    // compare received bytes against the expected queue
    task automatic compare_bytes(input string nome);
        checks++;
        if (rx_q.size() != exp_q.size())
            $display("FAIL %s_nbytes got=%0d exp=%0d", nome, rx_q.size(), exp_q.size());
        else passes++;
        while (exp_q.size() > 0) begin
            logic [7:0] e, r;
            e = exp_q.pop_front();
            r = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            checks++;
            if (r !== e) $display("FAIL %s_byte got=%h exp=%h", nome, r, e);
            else passes++;
        end
        rx_q.delete();
    endtask

    // one frame from a single-cycle enviar pulse; optional medida change and re-pulse
    task automatic test_frame(input logic [11:0] m, input int t_change, input logic [11:0] m2,
                              input int t_repulse, input string nome);
        int n;
        int pc0;
        bit achou;
        pc0 = pronto_cnt;
        for (int i = 0; i < NCH; i++) exp_q.push_back(exp_char(m, i));
        @(negedge clock);
        medida = m;
        enviar = 1'b1;
        @(negedge clock);
        enviar = 1'b0;
        n = 1;
        checks++; if (ocupado !== 1'b1) $display("FAIL %s_ocupado_start got=%b exp=1", nome, ocupado); else passes++;
        checks++; if (db_estado !== 4'h1) $display("FAIL %s_db_registra got=%h exp=1", nome, db_estado); else passes++;
        achou = 1'b0;
        while (!achou && n < 3000) begin
            if (n == 3) begin
                checks++;
                if (saida_serial !== 1'b0) $display("FAIL %s_start_bit got=%b exp=0", nome, saida_serial);
                else passes++;
            end
            if (n == t_change) medida = m2;
            if (n == t_repulse) enviar = 1'b1;
            else if (n == t_repulse + 1) enviar = 1'b0;
            if (pronto === 1'b1) achou = 1'b1;
            else begin
                @(negedge clock);
                n++;
            end
        end
        checks++;
        if (!achou || n != LAT) $display("FAIL %s_latency got=%0d exp=%0d", nome, achou ? n : -1, LAT);
        else passes++;
        @(negedge clock);
        checks++; if (ocupado !== 1'b0) $display("FAIL %s_ocupado_end got=%b exp=0", nome, ocupado); else passes++;
        checks++; if (pronto !== 1'b0) $display("FAIL %s_pronto_width got=%b exp=0", nome, pronto); else passes++;
        repeat (10) @(negedge clock);
        checks++;
        if (pronto_cnt - pc0 != 1) $display("FAIL %s_pronto_count got=%0d exp=1", nome, pronto_cnt - pc0);
        else passes++;
        compare_bytes(nome);
    endtask

    task automatic test_back_to_back();
        int n, n1, n2, pc0;
        pc0 = pronto_cnt;
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < NCH; i++) exp_q.push_back(exp_char(12'h678, i));
        @(negedge clock);
        medida = 12'h678;
        enviar = 1'b1;
        n = 0; n1 = -1; n2 = -1;
        while (n2 < 0 && n < 4000) begin
            @(negedge clock);
            n++;
            if (pronto === 1'b1) begin
                if (n1 < 0) n1 = n;
                else begin
                    n2 = n;
                    enviar = 1'b0;
                end
            end
        end
        enviar = 1'b0;
        checks++;
        if (n1 < 0 || n2 < 0 || n2 - n1 != LAT + 1)
            $display("FAIL b2b_interval got=%0d exp=%0d", n2 - n1, LAT + 1);
        else passes++;
        @(negedge clock);
        checks++; if (ocupado !== 1'b0) $display("FAIL b2b_ocupado_end got=%b exp=0", ocupado); else passes++;
        repeat (10) @(negedge clock);
        checks++;
        if (pronto_cnt - pc0 != 2) $display("FAIL b2b_pronto_count got=%0d exp=2", pronto_cnt - pc0);
        else passes++;
        compare_bytes("b2b");
    endtask

    task automatic test_reset_mid();
        int pc0;
        pc0 = pronto_cnt;
        @(negedge clock);
        medida = 12'h123;
        enviar = 1'b1;
        @(negedge clock);
        enviar = 1'b0;
        // cycle 1 reached; tens start bit spans cycles 49..52
        repeat (49) @(negedge clock);
        checks++; if (saida_serial !== 1'b0) $display("FAIL rst_mid_tens_start got=%b exp=0", saida_serial); else passes++;
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        checks++; if (saida_serial !== 1'b1) $display("FAIL rst_mid_line got=%b exp=1", saida_serial); else passes++;
        checks++; if (ocupado !== 1'b0) $display("FAIL rst_mid_ocupado got=%b exp=0", ocupado); else passes++;
        checks++; if (db_estado !== 4'h0) $display("FAIL rst_mid_db got=%h exp=0", db_estado); else passes++;
        repeat (100) @(negedge clock);
        checks++;
        if (pronto_cnt != pc0) $display("FAIL rst_mid_no_pronto got=%0d exp=0", pronto_cnt - pc0);
        else passes++;
        rx_q.delete();
        exp_q.delete();
        test_frame(12'h123, -10, 12'h000, -10, "rst_restart");
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(negedge clock);
        test_reset();
        reset = 1'b1;
        test_frame(12'h123, -10, 12'h000, -10, "f123");
        test_frame(12'h0A9, -10, 12'h000, -10, "f0a9");
        test_frame(12'h045, 2, 12'h999, -10, "f045_change");
        test_frame(12'h872, -10, 12'h000, 60, "f872_repulse");
        test_frame(12'h250, -10, 12'h000, -10, "f250");
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/envia_medida_serial.md
Name: envia_medida_serial

Overview:
Downstream of the ultrasonic sensor interface. Takes the 12-bit BCD distance (3 digits, cm) plus a send request, and transmits it as an ASCII frame "ddd#" over an asynchronous serial line (8N2, LSB first). The result drives the board's UART TX pin for a PC/terminal logger. It contains a control FSM, a character sequencer and a bit-level transmitter.

Parameters:
CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); legal range 2..65535.

Ports:
clock  in  1  system clock; all state changes on rising edge.
reset  in  1  synchronous, active-low reset: sampled on the rising edge of clock; reset=0 resets the block.
enviar  in  1  send request; level sampled each cycle, acted on only in IDLE.
medida  in  12  BCD distance: [11:8] hundreds, [7:4] tens, [3:0] units.
saida_serial  out  1  serial TX line; idle high.
ocupado  out  1  high from acceptance until pronto cycle inclusive.
pronto  out  1  one-cycle pulse when the whole frame is finished.
db_estado  out  4  FSM state code for the 7-segment debug display.

Behaviour:
- Reset (reset=0 at edge): state IDLE, saida_serial=1, ocupado=0, pronto=0, db_estado=0, char index=0, bit counters=0. Reset applies in any state, including mid-bit; the line is high from the next edge.
- FSM states and codes: IDLE=0, REGISTRA=1, TRANSMITE=2, ESPERA=3, PROXIMO=4, FIM=F.
- IDLE: on enviar=1 go to REGISTRA and latch medida into an internal register. Later changes on medida do not affect the frame in flight.
- REGISTRA (1 cycle): char index=0; go to TRANSMITE.
- TRANSMITE (1 cycle): load the current character into the bit shifter and start it; go to ESPERA.
- ESPERA: hold while the shifter runs; on shifter done, go to PROXIMO.
- PROXIMO (1 cycle): if index=3 go to FIM, else index+1 and go to TRANSMITE.
- FIM (1 cycle): pronto=1; go to IDLE.
- ocupado=1 in every state except IDLE.
- Character map:
  - index 0/1/2 = hundreds/tens/units.
  - Digit nibble 0..9 -> 8'h30+nibble.
  - Nibble 0xA..0xF -> 8'h3F ('?').
  - index 3 -> 8'h23 ('#').
- Bit frame per character: start bit 0, then data bits d0..d7, then two stop bits 1. That is 11 bits, each exactly CLKS_PER_BIT cycles.
- The start bit appears on saida_serial in the cycle after TRANSMITE. The shifter signals done on the last cycle of the second stop bit.
- Between characters, the line stays high for exactly the PROXIMO and TRANSMITE cycles, i.e. 2 idle cycles.
- Total latency: enviar accepted at edge E0. The first start bit begins at E0+3 cycles. pronto is high in the cycle after the final stop bit, which is E0 + 3 + 4*11*CLKS_PER_BIT + 3*2 + 1.
- enviar held high continuously: a new frame is accepted on the first IDLE cycle after FIM, with no gap beyond that. enviar while ocupado=1 is ignored, not queued.
- Bit-period counter: width = ceil(log2(CLKS_PER_BIT)); it wraps to 0 at CLKS_PER_BIT-1.
- Bit counter: 0..10; a terminal count at 10 with the period done means shifter done.

Optional Feature:
ENVIA_MEDIDA_CRLF_EN:
- Defined: the frame is 6 characters, "ddd#" followed by 8'h0D and 8'h0A. The index limit becomes 5 and pronto latency scales to 6 characters with 5 inter-character gaps.
- Not defined: exactly 4 characters "ddd#".

Decomposition:
- Shared package `envia_medida_pkg`:
  - state encodings (IDLE..FIM) as 4-bit localparams;
  - ASCII constants ZERO=8'h30, HASH=8'h23, QMARK=8'h3F, CR=8'h0D, LF=8'h0A;
  - bits-per-frame constant 11.
- One natural sub-module, `tx_serial_8n2`, with ports clock, reset, partida, dados[7:0], saida_serial, pronto_tx. It is parameterised by CLKS_PER_BIT.
- The FSM and character mux stay in the top.

Test Plan:
- CLKS_PER_BIT=4, medida=12'h123, enviar 1-cycle pulse -> line decodes 0x31,0x32,0x33,0x23; pronto pulses once at E0+3+176+6+1; ocupado low again afterwards.
- medida=12'h0A9 -> bytes 0x30,0x3F,0x39,0x23.
- Change medida to 12'h999 two cycles after accepting 12'h045 -> transmitted 0x30,0x34,0x35,0x23.
- Pulse enviar again during the second character -> ignored; exactly one frame and one pronto.
- reset=0 for one cycle in the middle of the tens start bit -> next cycle saida_serial=1, ocupado=0, db_estado=0; no pronto; a new enviar restarts from the hundreds digit.
- ENVIA_MEDIDA_CRLF_EN defined, medida=12'h250 -> 0x32,0x35,0x30,0x23,0x0D,0x0A, then pronto.
